// File: rtl/gyruss_audio_mixer_if.sv
// gyruss_audio_mixer_if: channel/gain inputs and mixed-sample outputs of the audio mixer
//   i_ch_in      : packed signed 16-bit samples, channel k at [16k+15:16k]
//   i_ch_gain    : packed unsigned Q1.7 gains, channel k at [8k+7:8k]
//   o_out        : signed mixed sample, held between updates
//   o_sample_stb : one-cycle pulse when o_out takes a new value
//   o_clip       : o_out was saturated
interface gyruss_audio_mixer_if #(parameter int CHANNELS = 5);
    logic [16*CHANNELS-1:0] i_ch_in;
    logic [8*CHANNELS-1:0]  i_ch_gain;
    logic signed [15:0]     o_out;
    logic                   o_sample_stb;
    logic                   o_clip;
    modport master (output i_ch_in, i_ch_gain, input o_out, o_sample_stb, o_clip);
    modport slave  (input i_ch_in, i_ch_gain, output o_out, o_sample_stb, o_clip);
endinterface

// File: rtl/gyruss_audio_mixer.sv
// gyruss_audio_mixer: gain-weighted sum of CHANNELS signed inputs into one saturated 16-bit sample every DIV cycles
//   clk   : system clock
//   reset : synchronous active-high reset
//   mix   : slave side of gyruss_audio_mixer_if (channel/gain inputs, out/sample_stb/clip outputs)
module gyruss_audio_mixer #(
    parameter int CHANNELS = 5,
    parameter int DIV      = 220
) (
    input  logic                 clk,
    input  logic                 reset,
    gyruss_audio_mixer_if.slave  mix
);
    localparam int CW = $clog2(DIV);
    localparam logic [2:0] LAST = 3'(CHANNELS - 1);

    generate
        if (CHANNELS < 1 || CHANNELS > 8 || DIV < CHANNELS + 2) begin : g_bad_params
            $error("gyruss_audio_mixer: need 1 <= CHANNELS <= 8 and DIV >= CHANNELS + 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_idx;
    logic signed [27:0] r_acc;
    logic signed [15:0] r_snap_in [8];
    logic [7:0]         r_snap_gain [8];
    logic signed [15:0] w_ch [8];
    logic [7:0]         w_gain [8];
    logic               w_tick;
    logic signed [24:0] w_prod;
    logic signed [20:0] w_s;

    // Unpack into fixed 8-entry arrays so the 3-bit index always addresses a real entry.
    for (genvar k = 0; k < 8; k++) begin : g_unpack
        if (k < CHANNELS) begin : g_used
            assign w_ch[k]   = mix.i_ch_in[16*k+15:16*k];
            assign w_gain[k] = mix.i_ch_gain[8*k+7:8*k];
        end else begin : g_unused
            assign w_ch[k]   = '0;
            assign w_gain[k] = '0;
        end
    end

    assign w_tick = r_cnt == CW'(DIV - 1);
    assign w_prod = r_snap_in[r_idx] * $signed({1'b0, r_snap_gain[r_idx]});
    // Dropping the low 7 bits of a two's-complement value is a floor divide by 128.
    assign w_s    = r_acc[27:7];

    always_ff @(posedge clk)
        r_state <= reset ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE && w_tick) ? ACCUM :
                 (r_state == ACCUM && r_idx == LAST) ? SAT :
                 (r_state == SAT) ? IDLE : r_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt            <= '0;
            r_idx            <= '0;
            r_acc            <= '0;
            r_snap_in        <= '{default: '0};
            r_snap_gain      <= '{default: '0};
            mix.o_out        <= '0;
            mix.o_sample_stb <= 1'b0;
            mix.o_clip       <= 1'b0;
        end else begin
            r_cnt            <= w_tick ? '0 : r_cnt + 1'b1;
            r_idx            <= (r_state == ACCUM) ? r_idx + 1'b1 : '0;
            r_acc            <= (r_state == IDLE) ? '0 : (r_state == ACCUM) ? r_acc + 28'(w_prod) : r_acc;
            mix.o_sample_stb <= r_state == SAT;
            if (w_tick) begin
                r_snap_in   <= w_ch;
                r_snap_gain <= w_gain;
            end
            if (r_state == SAT) begin
                mix.o_out  <= (w_s > 21'sd32767) ? 16'sh7fff : (w_s < -21'sd32768) ? 16'sh8000 : w_s[15:0];
                mix.o_clip <= (w_s > 21'sd32767) || (w_s < -21'sd32768);
            end
        end
    end
endmodule

// File: tb/tb_gyruss_audio_mixer.sv
// tb_gyruss_audio_mixer: directed and random checks of the mixer against an arithmetic reference model
module tb_gyruss_audio_mixer;
    localparam int CH  = 5;
    localparam int DIV = 220;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ch [CH];
    int   g  [CH];

    gyruss_audio_mixer_if #(.CHANNELS(CH)) bus ();
    gyruss_audio_mixer #(.CHANNELS(CH), .DIV(DIV)) dut (.clk(clk), .reset(reset), .mix(bus));

    always #10 clk = ~clk;

    // cyc holds the index of the next rising edge counted from reset release.
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int k = 0; k < CH; k++) begin
            bus.i_ch_in[16*k +: 16] = 16'(ch[k]);
            bus.i_ch_gain[8*k +: 8] = 8'(g[k]);
        end
    endtask

    task automatic set_all(input int c, input int gg);
        for (int k = 0; k < CH; k++) begin
            ch[k] = c;
            g[k]  = gg;
        end
    endtask

    // Sum of sample*gain, floor-divided by 128, clamped to 16-bit signed.
    task automatic model(output int eo, output int ec);
        longint sum = 0;
        longint s;
        for (int k = 0; k < CH; k++) sum += longint'(ch[k]) * longint'(g[k]);
        s = sum / 128;
        if (sum < 0 && sum % 128 != 0) s--;
        ec = (s > 32767 || s < -32768) ? 1 : 0;
        eo = (s > 32767) ? 32767 : (s < -32768) ? -32768 : int'(s);
    endtask

    task automatic wait_phase(input string tag, input int ph);
        int found = 0;
        for (int i = 0; i < 2 * DIV && found == 0; i++) begin
            @(negedge clk);
            if (cyc % DIV == ph) found = 1;
        end
        chk(tag, found, 1);
    endtask

    task automatic check_sample(input string tag, input int eo, input int ec, output int at);
        at = -1;
        for (int i = 0; i < 2 * DIV && at < 0; i++) begin
            @(negedge clk);
            if (bus.o_sample_stb) at = cyc;
        end
        chk({tag, "_stb"}, (at >= 0) ? 1 : 0, 1);
        chk({tag, "_out"}, bus.o_out, eo);
        chk({tag, "_clip"}, bus.o_clip, ec);
        @(negedge clk);
        chk({tag, "_pulse"}, bus.o_sample_stb, 0);
    endtask

    task automatic sample(input string tag, output int at);
        int eo, ec;
        model(eo, ec);
        check_sample(tag, eo, ec, at);
    endtask

    initial begin
        int at, prev, eo, ec, bad;
        set_all(0, 128);
        ch[0] = 1000;
        apply();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", bus.o_out, 0);
        chk("rst_clip", bus.o_clip, 0);
        chk("rst_stb", bus.o_sample_stb, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        sample("unity", at);
        chk("unity_first_cycle", at, 226);
        sample("unity2", at);
        chk("unity_second_cycle", at, 446);

        set_all(32767, 255); apply();
        sample("pos_sat", at);
        set_all(32767, 0); apply();
        sample("zero_gain", at);

        set_all(-32768, 255); apply();
        sample("neg_sat", at);
        set_all(0, 0); ch[0] = -1; g[0] = 64; apply();
        sample("floor_neg", at);
        ch[0] = 1; apply();
        sample("floor_pos", at);

        ch = '{100, -200, 300, -400, 500};
        g  = '{128, 128, 128, 128, 128};
        apply();
        sample("mixed", at);
        g[2] = 64; apply();
        sample("mixed_g2", at);

        // Input change two cycles after the tick must not reach the sample in flight.
        set_all(0, 128); ch[0] = 1000; apply();
        model(eo, ec);
        wait_phase("snap_phase", 1);
        ch[0] = -5000; apply();
        check_sample("snap_old", eo, ec, at);
        sample("snap_new", at);

        prev = at;
        for (int n = 0; n < 10; n++) begin
            for (int k = 0; k < CH; k++) begin
                ch[k] = (n % 2 == 0) ? int'($urandom_range(4000)) - 2000 : int'($urandom_range(65535)) - 32768;
                g[k]  = int'($urandom_range(255));
            end
            apply();
            sample("rand", at);
            chk("rand_period", at - prev, DIV);
            prev = at;
        end

        // Reset for one edge in the middle of accumulation abandons the sample.
        set_all(1000, 128); apply();
        wait_phase("rst_phase", 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model(eo, ec);
        bad = 0;
        at = -1;
        for (int i = 0; i < 2 * DIV && at < 0; i++) begin
            @(negedge clk);
            if (bus.o_sample_stb) at = cyc;
            else if (bus.o_out !== 16'sd0 || bus.o_clip !== 1'b0) bad++;
        end
        chk("rst_mid_hold", bad, 0);
        chk("rst_mid_first_cycle", at, 226);
        chk("rst_mid_out", bus.o_out, eo);
        chk("rst_mid_clip", bus.o_clip, ec);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
